// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage xgriscv pipeline: operand forwarding, stall/flush/redirect
// generation, data-memory wait sequencing with timeout, and stall/redirect performance counters.
module hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rs1D,
   input  logic [4:0]       rs2D,
   input  logic             users1D,
   input  logic             users2D,
   input  logic [4:0]       rs1E,
   input  logic [4:0]       rs2E,
   input  logic [4:0]       rdE,
   input  logic             regwriteE,
   input  logic             memtoregE,
   input  logic             pcsrcE,
   input  logic [4:0]       rdM,
   input  logic             regwriteM,
   input  logic             memtoregM,
   input  logic             jM,
   input  logic             memreqM,
   input  logic             memreadyM,
   input  logic [4:0]       rdW,
   input  logic             regwriteW,
   output logic [1:0]       forwardaE,
   output logic [1:0]       forwardbE,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             stallM,
   output logic             flushD,
   output logic             flushE,
   output logic             flushW,
   output logic             redirect,
   output logic             memerr,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] redirect_cnt
);

   localparam int unsigned WaitW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [0:0] {StRun, StMwait} stateT;

   stateT             state, stateNext;
   logic [WaitW-1:0]  waitCnt, waitCntNext;
   logic              memerrNext;
   logic              memPending, atLimit, memStall, redir, loadUse, timeout;

   function automatic logic [1:0] fwdSel(input logic [4:0] rs, input logic [4:0] rdMemI,
                                         input logic wrM, input logic ldM, input logic jalM,
                                         input logic [4:0] rdWbI, input logic wrW);
      logic [1:0] sel;
      sel = 2'b00;
      if (wrM && jalM && rdMemI != 5'd0 && rdMemI == rs) begin
         sel = 2'b11;
      end else if (wrM && !ldM && rdMemI != 5'd0 && rdMemI == rs) begin
         sel = 2'b10;
      end else if (wrW && rdWbI != 5'd0 && rdWbI == rs) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   assign memPending = memreqM && !memreadyM;
   assign atLimit    = (waitCnt == WaitW'(MEM_TIMEOUT));
   assign memStall   = memPending && !atLimit;
   // The limit is only reachable from MWAIT since RUN always holds a zero count.
   assign timeout    = (state == StMwait) && memPending && atLimit;
   assign redir      = pcsrcE && !memStall;
   assign loadUse    = regwriteE && memtoregE && rdE != 5'd0 &&
                       ((users1D && rdE == rs1D) || (users2D && rdE == rs2D));

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= StRun;
         waitCnt      <= '0;
         memerr       <= 1'b0;
         stall_cnt    <= '0;
         redirect_cnt <= '0;
      end else begin
         state   <= stateNext;
         waitCnt <= waitCntNext;
         memerr  <= memerrNext;
         if (stallF) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (redirect) begin
            redirect_cnt <= redirect_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      stateNext   = StRun;
      waitCntNext = '0;
      memerrNext  = memerr;
      if (memStall) begin
         stateNext   = StMwait;
         waitCntNext = waitCnt + WaitW'(1);
      end
      if (timeout) begin
         memerrNext = 1'b1;
      end
   end

   always_comb begin
      forwardaE = 2'b00;
      forwardbE = 2'b00;
      stallF    = 1'b0;
      stallD    = 1'b0;
      stallE    = 1'b0;
      stallM    = 1'b0;
      flushD    = 1'b0;
      flushE    = 1'b0;
      flushW    = 1'b0;
      redirect  = 1'b0;
      if (!reset) begin
         forwardaE = fwdSel(rs1E, rdM, regwriteM, memtoregM, jM, rdW, regwriteW);
         forwardbE = fwdSel(rs2E, rdM, regwriteM, memtoregM, jM, rdW, regwriteW);
         if (memStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
         end else if (redir) begin
            redirect = 1'b1;
            flushD   = 1'b1;
            flushE   = 1'b1;
         end else if (loadUse) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: forwarding, load-use, redirect, memory wait,
// timeout and reset behaviour.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic        users1D, users2D, regwriteE, memtoregE, pcsrcE;
   logic        regwriteM, memtoregM, jM, memreqM, memreadyM, regwriteW;
   logic [1:0]  forwardaE, forwardbE;
   logic        stallF, stallD, stallE, stallM, flushD, flushE, flushW, redirect, memerr;
   logic [31:0] stall_cnt, redirect_cnt;
   logic [7:0]  ctl;

   int checks = 0;
   int errors = 0;

   hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .rs1D(rs1D), .rs2D(rs2D), .users1D(users1D), .users2D(users2D),
      .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .regwriteE(regwriteE), .memtoregE(memtoregE),
      .pcsrcE(pcsrcE), .rdM(rdM), .regwriteM(regwriteM), .memtoregM(memtoregM), .jM(jM),
      .memreqM(memreqM), .memreadyM(memreadyM), .rdW(rdW), .regwriteW(regwriteW),
      .forwardaE(forwardaE), .forwardbE(forwardbE),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .flushD(flushD), .flushE(flushE), .flushW(flushW), .redirect(redirect),
      .memerr(memerr), .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
   );

   always #5 clk = ~clk;

   // {stallF, stallD, stallE, stallM, flushD, flushE, flushW, redirect}
   assign ctl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW, redirect};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
      {users1D, users2D, regwriteE, memtoregE, pcsrcE} = '0;
      {regwriteM, memtoregM, jM, memreqM, memreadyM, regwriteW} = '0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic pulseReset();
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      // Outputs forced low while reset is held, even with a forwarding match present.
      rdM = 5'd5; regwriteM = 1'b1; rs1E = 5'd5;
      smp();
      chk("reset_fwda", {30'd0, forwardaE}, 32'd0);
      chk("reset_ctl", {24'd0, ctl}, 32'd0);
      cyc();
      chk("reset_memerr", {31'd0, memerr}, 32'd0);
      chk("reset_stallcnt", stall_cnt, 32'd0);
      chk("reset_redircnt", redirect_cnt, 32'd0);
      reset = 1'b0;

      // ALU forward from MEM beats WB
      idle();
      rdM = 5'd5; regwriteM = 1'b1; rs1E = 5'd5; rdW = 5'd5; regwriteW = 1'b1; rs2E = 5'd6;
      smp();
      chk("alu_fwd_a", {30'd0, forwardaE}, 32'd2);
      chk("alu_fwd_b", {30'd0, forwardbE}, 32'd0);
      cyc();
      memtoregM = 1'b1; rs2E = 5'd5;
      smp();
      chk("load_in_mem_wb_fwd", {30'd0, forwardbE}, 32'd1);

      // JAL forward
      cyc();
      idle();
      jM = 1'b1; rdM = 5'd1; regwriteM = 1'b1; rs2E = 5'd1;
      smp();
      chk("jal_fwd", {30'd0, forwardbE}, 32'd3);
      cyc();
      rdM = 5'd0; rs2E = 5'd0; regwriteW = 1'b1; rdW = 5'd0;
      smp();
      chk("jal_x0", {30'd0, forwardbE}, 32'd0);

      // Load-use
      cyc();
      idle();
      regwriteE = 1'b1; memtoregE = 1'b1; rdE = 5'd7; rs2D = 5'd7; users2D = 1'b1;
      smp();
      chk("loaduse_ctl", {24'd0, ctl}, {24'd0, 8'b1100_0100});
      chk("loaduse_cnt_before", stall_cnt, 32'd0);
      cyc();
      users2D = 1'b0;
      smp();
      chk("loaduse_cnt_after", stall_cnt, 32'd1);
      chk("loaduse_unused", {24'd0, ctl}, 32'd0);
      cyc();
      rdE = 5'd0; rs1D = 5'd0; users1D = 1'b1;
      smp();
      chk("loaduse_x0", {24'd0, ctl}, 32'd0);

      // Redirect wins over load-use
      cyc();
      idle();
      regwriteE = 1'b1; memtoregE = 1'b1; rdE = 5'd7; rs1D = 5'd7; users1D = 1'b1;
      pcsrcE = 1'b1;
      smp();
      chk("redir_ctl", {24'd0, ctl}, {24'd0, 8'b0000_1101});
      cyc();
      idle();
      smp();
      chk("redir_cnt", redirect_cnt, 32'd1);
      chk("redir_stallcnt", stall_cnt, 32'd1);

      // Memory wait with deferred redirect
      pulseReset();
      chk("mw_cnt_cleared", stall_cnt, 32'd0);
      memreqM = 1'b1; memreadyM = 1'b0; pcsrcE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk($sformatf("mw_stall_%0d", i), {24'd0, ctl}, {24'd0, 8'b1111_0010});
         cyc();
      end
      memreadyM = 1'b1;
      smp();
      chk("mw_ready_redir", {24'd0, ctl}, {24'd0, 8'b0000_1101});
      cyc();
      idle();
      smp();
      chk("mw_stallcnt", stall_cnt, 32'd3);
      chk("mw_redircnt", redirect_cnt, 32'd1);
      chk("mw_memerr", {31'd0, memerr}, 32'd0);

      // Timeout
      pulseReset();
      memreqM = 1'b1; memreadyM = 1'b0;
      for (int i = 0; i < 16; i++) begin
         smp();
         chk($sformatf("to_stall_%0d", i), {31'd0, stallM}, 32'd1);
         cyc();
      end
      smp();
      chk("to_forced_through", {24'd0, ctl}, 32'd0);
      chk("to_memerr_not_yet", {31'd0, memerr}, 32'd0);
      cyc();
      memreqM = 1'b0;
      smp();
      chk("to_memerr", {31'd0, memerr}, 32'd1);
      chk("to_stallcnt", stall_cnt, 32'd16);

      // New access stalls, reset mid-wait aborts it and clears state
      cyc();
      memreqM = 1'b1;
      smp();
      chk("mw2_stall", {31'd0, stallF}, 32'd1);
      cyc();
      reset = 1'b1;
      smp();
      chk("rst_mid_wait_ctl", {24'd0, ctl}, 32'd0);
      cyc();
      reset = 1'b0;
      memreqM = 1'b0;
      smp();
      chk("rst_memerr", {31'd0, memerr}, 32'd0);
      chk("rst_stallcnt", stall_cnt, 32'd0);
      chk("rst_redircnt", redirect_cnt, 32'd0);
      // After reset the wait count restarts: a pending access stalls the full budget again.
      cyc();
      memreqM = 1'b1;
      for (int i = 0; i < 16; i++) begin
         smp();
         chk($sformatf("rst_run_stall_%0d", i), {31'd0, stallF}, 32'd1);
         cyc();
      end
      smp();
      chk("rst_run_limit", {31'd0, stallF}, 32'd0);
      cyc();
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
